// File: rtl/mem_bridge_rv_if.sv
// Single-ported valid/ready memory bus between mem_bridge_rv (master) and memory (slave).
// Writes complete on acceptance; reads return one rvalid beat at least one cycle after acceptance.
interface mem_bridge_rv_if;
  logic        busValid;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busWstrb;
  logic        busReady;
  logic [31:0] busRdata;
  logic        busRvalid;

  modport master (
    output busValid, busWrite, busAddr, busWdata, busWstrb,
    input  busReady, busRdata, busRvalid
  );

  modport slave (
    input  busValid, busWrite, busAddr, busWdata, busWstrb,
    output busReady, busRdata, busRvalid
  );
endinterface

// File: rtl/mem_bridge_rv.sv
// Serialises the single-cycle RV core's fetch/load/store ports onto one valid/ready bus, one access at a time.
// Optional MEM_BRIDGE_IBUF_EN adds a one-entry fetch buffer that skips the bus fetch on a PC hit.
module mem_bridge_rv #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          iwClk,
  input  logic          iwRst,
  input  logic [31:0]   iwRead1Addr,
  input  logic [31:0]   iwRead2Addr,
  input  logic          iwRead2En,
  input  logic [31:0]   iwWriteAddr,
  input  logic [31:0]   iwWriteData,
  input  logic [3:0]    iwWstrb,
  output logic [31:0]   owRead1Data,
  output logic [31:0]   owRead2Data,
  output logic          owStall,
  output logic          owBusErr,
  mem_bridge_rv_if.master bus
);

  typedef enum logic [2:0] {F_REQ, F_WAIT, L_REQ, L_WAIT, S_REQ, STEP} state_t;

  state_t      state, stateNext;
  logic [31:0] tmoCnt;
  logic        waiting, tmoFire, tmoHit;
  logic        load1, load2;
  logic [31:0] rdLatch;
  logic        ibHit, ibFill, ibInval;
  logic [31:0] ibData;
  state_t      afterFetch, afterLoad;

  function automatic logic [31:0] wordAddr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] shiftData(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [3:0] shiftStrb(input logic [3:0] s, input logic [1:0] off);
    return s << off;
  endfunction

  assign tmoHit     = (TIMEOUT_CYCLES != 0) && (tmoCnt == 32'(TIMEOUT_CYCLES - 1));
  assign afterLoad  = (iwWstrb != 4'b0000) ? S_REQ : STEP;
  assign afterFetch = iwRead2En ? L_REQ : afterLoad;

  // A timed-out read completes with a zero word so the core is never held forever.
  always_comb begin
    stateNext     = state;
    bus.busValid  = 1'b0;
    bus.busWrite  = 1'b0;
    bus.busAddr   = '0;
    bus.busWdata  = '0;
    bus.busWstrb  = '0;
    owStall       = 1'b1;
    waiting       = 1'b0;
    tmoFire       = 1'b0;
    load1         = 1'b0;
    load2         = 1'b0;
    rdLatch       = '0;
    ibFill        = 1'b0;
    ibInval       = 1'b0;
    case (state)
      F_REQ: begin
        if (ibHit) begin
          load1     = 1'b1;
          rdLatch   = ibData;
          stateNext = afterFetch;
        end else begin
          bus.busValid = 1'b1;
          bus.busAddr  = wordAddr(iwRead1Addr);
          if (bus.busReady) begin
            stateNext = F_WAIT;
          end else begin
            waiting = 1'b1;
            if (tmoHit) begin
              tmoFire   = 1'b1;
              load1     = 1'b1;
              stateNext = afterFetch;
            end
          end
        end
      end
      F_WAIT: begin
        if (bus.busRvalid) begin
          load1     = 1'b1;
          rdLatch   = bus.busRdata;
          ibFill    = 1'b1;
          stateNext = afterFetch;
        end else begin
          waiting = 1'b1;
          if (tmoHit) begin
            tmoFire   = 1'b1;
            load1     = 1'b1;
            stateNext = afterFetch;
          end
        end
      end
      L_REQ: begin
        bus.busValid = 1'b1;
        bus.busAddr  = wordAddr(iwRead2Addr);
        if (bus.busReady) begin
          stateNext = L_WAIT;
        end else begin
          waiting = 1'b1;
          if (tmoHit) begin
            tmoFire   = 1'b1;
            load2     = 1'b1;
            stateNext = afterLoad;
          end
        end
      end
      L_WAIT: begin
        if (bus.busRvalid) begin
          load2     = 1'b1;
          rdLatch   = bus.busRdata;
          stateNext = afterLoad;
        end else begin
          waiting = 1'b1;
          if (tmoHit) begin
            tmoFire   = 1'b1;
            load2     = 1'b1;
            stateNext = afterLoad;
          end
        end
      end
      S_REQ: begin
        bus.busValid = 1'b1;
        bus.busWrite = 1'b1;
        bus.busAddr  = wordAddr(iwWriteAddr);
        bus.busWdata = shiftData(iwWriteData, iwWriteAddr[1:0]);
        bus.busWstrb = shiftStrb(iwWstrb, iwWriteAddr[1:0]);
        if (bus.busReady) begin
          ibInval   = 1'b1;
          stateNext = STEP;
        end else begin
          waiting = 1'b1;
          if (tmoHit) begin
            tmoFire   = 1'b1;
            ibInval   = 1'b1;
            stateNext = STEP;
          end
        end
      end
      STEP: begin
        owStall   = 1'b0;
        stateNext = F_REQ;
      end
      default: stateNext = F_REQ;
    endcase
    // Nothing is offered to the bus while reset is held.
    if (iwRst) begin
      bus.busValid = 1'b0;
      bus.busWrite = 1'b0;
      bus.busAddr  = '0;
      bus.busWdata = '0;
      bus.busWstrb = '0;
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state       <= F_REQ;
      tmoCnt      <= '0;
      owBusErr    <= 1'b0;
      owRead1Data <= 32'h0000_0013;
      owRead2Data <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state) tmoCnt <= '0;
      else if (waiting)       tmoCnt <= tmoCnt + 32'd1;
      if (tmoFire) owBusErr    <= 1'b1;
      if (load1)   owRead1Data <= rdLatch;
      if (load2)   owRead2Data <= rdLatch;
    end
  end

`ifdef MEM_BRIDGE_IBUF_EN
  logic        ibValid;
  logic [29:0] ibAddr;
  logic [31:0] ibWord;

  assign ibHit  = ibValid && (ibAddr == iwRead1Addr[31:2]);
  assign ibData = ibWord;

  // A store to the buffered word must force the next fetch of it back onto the bus.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      ibValid <= 1'b0;
    end else if (ibInval && ibValid && (ibAddr == iwWriteAddr[31:2])) begin
      ibValid <= 1'b0;
    end else if (ibFill) begin
      ibValid <= 1'b1;
      ibAddr  <= iwRead1Addr[31:2];
      ibWord  <= bus.busRdata;
    end
  end
`else
  logic unusedIb;
  assign ibHit    = 1'b0;
  assign ibData   = '0;
  assign unusedIb = ibFill | ibInval;
`endif

  logic unusedAddrBits;
  assign unusedAddrBits = ^{iwRead1Addr[1:0], iwRead2Addr[1:0]};

endmodule
